// File: rtl/fp16_accum_seq_pkg.sv
// fp16_accum_seq_pkg: constants shared by the FP16 accumulation sequencer.
//   - FSM state encoding (legacy 2-bit constants)
//   - FP16 constants used for accumulator initialisation
//   - latency of the attached pipelined add/sub unit
package fp16_accum_seq_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    localparam logic [15:0] FP16_ZERO = 16'h0000;
    localparam logic [15:0] FP16_ONE  = 16'h3C00;

    localparam int unsigned AU_LATENCY = 3;

endpackage

// File: rtl/fp16_accum_seq_watchdog.sv
// fp16_acc_watchdog: counts consecutive WAIT cycles and flags expiry.
// Only compiled when FP16_ACC_TIMEOUT_EN is defined.
// Ports:
//   CLK      rising-edge clock
//   Reset_n  asynchronous active-low reset
//   clear    synchronous counter clear (held while not waiting)
//   enable   count this cycle
//   expire   high during the TIMEOUT-th enabled cycle
`ifdef FP16_ACC_TIMEOUT_EN
module fp16_acc_watchdog #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic CLK,
    input  logic Reset_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned W = $clog2(TIMEOUT + 1);

    logic [W-1:0] wait_cnt;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            wait_cnt <= '0;
        end else if (clear) begin
            wait_cnt <= '0;
        end else if (enable && !expire) begin
            wait_cnt <= wait_cnt + W'(1);
        end
    end

    // wait_cnt holds the number of completed enabled cycles, so the
    // TIMEOUT-th cycle is the one where it equals TIMEOUT-1.
    assign expire = enable && (wait_cnt == W'(TIMEOUT - 1));

endmodule
`endif

// File: rtl/fp16_accum_seq.sv
// fp16_accum_seq: sequencing front-end for the pipelined FP16 add/sub unit.
// Accepts FP16 operands (valid/ready), folds each into a running accumulator
// with one add/sub per operand (one operation in flight), and presents the
// frame sum on a valid/ready result port.
// Optional feature: define FP16_ACC_TIMEOUT_EN to compile in a WAIT watchdog
// that aborts a stalled operation with Res_Err = 1.
// Ports:
//   CLK, Reset_n                      clock, async active-low reset
//   In_Valid/In_Ready/In_Data/In_Sub/In_Last   operand stream
//   Au_A/Au_B/Au_Select/Au_Start      request to the add/sub unit
//   Au_Out/Au_Done                    response from the add/sub unit
//   Res_Valid/Res_Ready/Res_Data/Res_Count/Res_Err   frame result
module fp16_accum_seq
    import fp16_accum_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [15:0]      In_Data,
    input  logic             In_Sub,
    input  logic             In_Last,
    output logic [15:0]      Au_A,
    output logic [15:0]      Au_B,
    output logic             Au_Select,
    output logic             Au_Start,
    input  logic [15:0]      Au_Out,
    input  logic             Au_Done,
    output logic             Res_Valid,
    input  logic             Res_Ready,
    output logic [15:0]      Res_Data,
    output logic [CNT_W-1:0] Res_Count,
    output logic             Res_Err
);

    logic [1:0]       state;
    logic [15:0]      acc;
    logic [CNT_W-1:0] count;
    logic [15:0]      op_data;
    logic             op_sub;
    logic             op_last;
    logic             wd_expire;

`ifdef FP16_ACC_TIMEOUT_EN
    logic err;

    fp16_acc_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .clear   (state != ST_WAIT),
        .enable  (state == ST_WAIT),
        .expire  (wd_expire)
    );

    assign Res_Err = err;
`else
    assign wd_expire = 1'b0;
    assign Res_Err   = 1'b0;
`endif

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= ST_IDLE;
            acc     <= FP16_ZERO;
            count   <= '0;
            op_data <= FP16_ZERO;
            op_sub  <= 1'b0;
            op_last <= 1'b0;
`ifdef FP16_ACC_TIMEOUT_EN
            err     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (In_Valid) begin
                        op_data <= In_Data;
                        op_sub  <= In_Sub;
                        op_last <= In_Last;
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Done wins over a same-cycle watchdog expiry.
                    if (Au_Done) begin
                        acc <= Au_Out;
                        if (count != '1) begin
                            count <= count + CNT_W'(1);
                        end
                        state <= op_last ? ST_OUT : ST_IDLE;
                    end else if (wd_expire) begin
`ifdef FP16_ACC_TIMEOUT_EN
                        err <= 1'b1;
`endif
                        state <= ST_OUT;
                    end
                end
                default: begin // ST_OUT
                    if (Res_Ready) begin
                        acc   <= FP16_ZERO;
                        count <= '0;
`ifdef FP16_ACC_TIMEOUT_EN
                        err   <= 1'b0;
`endif
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Au_A tracks the accumulator directly; it only changes on Done, so it
    // is stable across ISSUE and WAIT as the unit requires.
    assign Au_A      = acc;
    assign Au_B      = op_data;
    assign Au_Select = op_sub;
    assign Au_Start  = (state == ST_ISSUE);

    assign In_Ready  = (state == ST_IDLE);
    assign Res_Valid = (state == ST_OUT);
    assign Res_Data  = acc;
    assign Res_Count = count;

endmodule
